// File: rtl/slow_peripheral_pkg.sv
// Shared widths and the read-response record for the slow-peripheral responder.
// The optional endofpacket feature is SLOW_PERIPH_EOP_EN (see slow_peripheral_responder.sv).
package slow_peripheral_pkg;

  localparam int DATA_W        = 32;
  localparam int BE_W          = 4;
  localparam int NATIVE_ADDR_W = 12;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              eop;
  } resp_t;

endpackage

// File: rtl/slow_peripheral_resp_pipe.sv
// Fixed-depth read-response shift register with synchronous clear.
// With SLOW_PERIPH_EOP_EN defined an eop bit travels alongside each response.
module slow_peripheral_resp_pipe
  import slow_peripheral_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic  clk,
  input  logic  reset_n,
  input  logic  in_valid_i,
  input  resp_t in_resp_i,
  output logic  out_valid_o,
  output resp_t out_resp_o
);

  logic [DEPTH-1:0]  valid_q;
  logic [DATA_W-1:0] data_q [DEPTH];

  // Data only moves with a valid entry, so the last stage keeps the most
  // recent response through bubbles and readdata holds between strobes.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q[0] <= in_valid_i;
      if (in_valid_i) begin
        data_q[0] <= in_resp_i.data;
      end
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        if (valid_q[i-1]) begin
          data_q[i] <= data_q[i-1];
        end
      end
    end
  end

  assign out_valid_o     = valid_q[DEPTH-1];
  assign out_resp_o.data = data_q[DEPTH-1];

`ifdef SLOW_PERIPH_EOP_EN
  logic [DEPTH-1:0] eop_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      eop_q <= '0;
    end else begin
      eop_q[0] <= in_valid_i & in_resp_i.eop;
      for (int i = 1; i < DEPTH; i++) begin
        eop_q[i] <= eop_q[i-1];
      end
    end
  end

  assign out_resp_o.eop = valid_q[DEPTH-1] & eop_q[DEPTH-1];
`else
  logic unused_eop;
  assign unused_eop     = in_resp_i.eop;
  assign out_resp_o.eop = 1'b0;
`endif

endmodule

// File: rtl/slow_peripheral_responder.sv
// Avalon-MM pipelined slave: byte-writable register bank, programmable wait states,
// fixed-latency reads with a pending-read limit. Optional macro: SLOW_PERIPH_EOP_EN.
module slow_peripheral_responder
  import slow_peripheral_pkg::*;
#(
  parameter int ADDR_W       = 4,
  parameter int WAIT_STATES  = 1,
  parameter int READ_LATENCY = 2,
  parameter int MAX_PENDING  = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NATIVE_ADDR_W-1:0] nativeaddress,
  input  logic [BE_W-1:0]          byteenable,
  input  logic                     read,
  input  logic                     write,
  input  logic [DATA_W-1:0]        writedata,
  output logic                     waitrequest,
  output logic [DATA_W-1:0]        readdata,
  output logic                     readdatavalid,
  output logic                     endofpacket
);

  localparam int         BANK_DEPTH = 1 << ADDR_W;
  localparam logic [3:0] WS_MAX     = 4'(WAIT_STATES);
  localparam logic [3:0] PEND_MAX   = 4'(MAX_PENDING);

  logic [DATA_W-1:0] bank_q [BANK_DEPTH];
  logic [3:0]        ws_cnt_q, ws_cnt_d;
  logic [3:0]        pending_q, pending_d;

  logic              req, is_read, accept, wr_accept, rd_accept, in_range;
  logic [ADDR_W-1:0] word_idx;
  resp_t             rd_resp, out_resp;
  logic              out_valid;

  // A simultaneous read+write is a write; only pure reads count against the limit.
  assign req      = read | write;
  assign is_read  = read & ~write;
  assign word_idx = nativeaddress[ADDR_W-1:0];
  assign in_range = (nativeaddress >> ADDR_W) == '0;

  assign waitrequest = req & ((ws_cnt_q != WS_MAX) |
                              (is_read & (pending_q == PEND_MAX)));
  assign accept      = req & ~waitrequest;
  assign wr_accept   = accept & write & in_range;
  assign rd_accept   = accept & is_read;

  always_comb begin
    ws_cnt_d = ws_cnt_q;
    if (!req || accept) begin
      ws_cnt_d = '0;
    end else if (ws_cnt_q != WS_MAX) begin
      ws_cnt_d = ws_cnt_q + 4'd1;
    end
  end

  always_comb begin
    pending_d = pending_q;
    if (rd_accept && !out_valid) begin
      pending_d = pending_q + 4'd1;
    end else if (!rd_accept && out_valid) begin
      pending_d = pending_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ws_cnt_q  <= '0;
      pending_q <= '0;
    end else begin
      ws_cnt_q  <= ws_cnt_d;
      pending_q <= pending_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int w = 0; w < BANK_DEPTH; w++) begin
        bank_q[w] <= '0;
      end
    end else if (wr_accept) begin
      for (int b = 0; b < BE_W; b++) begin
        if (byteenable[b]) begin
          bank_q[word_idx][b*8 +: 8] <= writedata[b*8 +: 8];
        end
      end
    end
  end

  // Out-of-range reads still flow through the pipe, carrying zero data.
  assign rd_resp.data = in_range ? bank_q[word_idx] : '0;
  assign rd_resp.eop  = in_range & (&word_idx);

  slow_peripheral_resp_pipe #(
    .DEPTH(READ_LATENCY)
  ) u_resp_pipe (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid_i (rd_accept),
    .in_resp_i  (rd_resp),
    .out_valid_o(out_valid),
    .out_resp_o (out_resp)
  );

  assign readdatavalid = out_valid;
  assign readdata      = out_resp.data;
  assign endofpacket   = out_resp.eop;

endmodule
